memory_load_unit: RTL
=====================

# memory_load_unit

Fetch stage feeding the register file's memory-load path. On a `start` pulse it issues one read request to memory, waits for the acknowledge, captures the returned word, and presents it on `mem_data` with a one-cycle `sel_memory` strobe. These outputs connect directly to a register's `memory` / `sel_memory` inputs. An optional timeout aborts requests that are never acknowledged.

## Interface
- `WORD`, 16: data word width; taken from the shared definition file.
- `ADDR`, 8: memory address width.
- `TIMEOUT`, 15: maximum cycles spent in REQ without an ack; range 1..255. Used only when timeout is compiled in.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset. Asserting low clears all state immediately.
- `start`  in  1  load request; sampled only in IDLE.
- `addr`  in  ADDR  load address; captured with `start`.
- `busy`  out  1  high in every state except IDLE.
- `mem_req`  out  1  read request to memory.
- `mem_addr`  out  ADDR  read address; stable while `mem_req` is high.
- `mem_ack`  in  1  memory acknowledge, single-cycle; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  WORD  read data from memory.
- `mem_data`  out  WORD  last successfully loaded word; connects to the register's `memory` input.
- `sel_memory`  out  1  one-cycle load strobe to the register.
- `err`  out  1  one-cycle timeout flag; constant 0 when timeout is compiled out.

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - `start`=1: latch `addr` into `mem_addr`, clear the timeout counter, go to REQ.
  - `mem_ack` is ignored.
- REQ:
  - `mem_req`=1.
  - `mem_ack`=1: capture `mem_rdata` into `mem_data`, go to DONE.
  - Otherwise the counter increments. If timeout is enabled and the counter reaches `TIMEOUT`, go to ERR.
  - If `mem_ack` arrives in the same cycle the counter reaches `TIMEOUT`, the ack wins.
- DONE: `sel_memory`=1 for exactly this cycle, then go to IDLE.
- ERR: `err`=1 for exactly this cycle, `mem_data` is unchanged, then go to IDLE.
- `start` in any state other than IDLE is ignored and not queued.
- `mem_data` holds its value until the next successful capture; a timeout never modifies it.
- Timeout counter is 8 bits wide and saturates; it never wraps.
- `mem_addr` holds its latched value after the transaction until the next accepted `start`.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `mem_req`=0, `mem_addr`=0, `mem_data`=0, `sel_memory`=0, `err`=0, state=IDLE, counter=0.
- Load sequence:
  - `start` sampled at edge 0 → `mem_req`=1 and `busy`=1 from edge 0.
  - `mem_ack` sampled at edge k → `mem_data` updated and `sel_memory`=1 from edge k; the earliest case is k=1.
  - `busy` and `sel_memory` drop at edge k+1. A new `start` is accepted at edge k+1 at the earliest.
  - Minimum start-to-strobe latency: 2 cycles.
- Timeout: with no ack, `mem_req` stays high for `TIMEOUT` cycles, then `err` pulses for one cycle with `mem_req`=0.
- `reset` asserted mid-transaction: `mem_req` and all strobes drop asynchronously; no partial `sel_memory` or `err` is emitted after release.
- Reset release is synchronized by the system; the first `start` is honoured at the first edge after deassertion.

## Configuration
- Macro: `MEM_LOAD_TIMEOUT_EN`.
- Defined: timeout counter and ERR state are implemented, and `err` behaves as described above.
- Undefined: no counter; REQ waits indefinitely for `mem_ack`, ERR is unreachable, and `err` is tied to 0.

## Test plan
- Reset, then `start` with `addr`=0x3C; memory acks 3 cycles after `mem_req` rises with `mem_rdata`=0xBEEF → `mem_addr`=0x3C throughout REQ; `mem_data`=0xBEEF and `sel_memory` high for exactly 1 cycle; `busy` returns to 0.
- Memory acks on the first REQ cycle with 0x1234 → `sel_memory` asserted 2 cycles after `start`; back-to-back `start` on the cycle after the strobe is accepted.
- `start` pulsed 3 times while `busy` → exactly one `mem_req` transaction and one `sel_memory` pulse.
- `MEM_LOAD_TIMEOUT_EN` defined, `TIMEOUT`=15, no ack → `mem_req` high for 15 cycles, `err` pulses once, `mem_data` retains its prior value 0xBEEF, `sel_memory` never asserts.
- Ack coincident with timeout expiry → `sel_memory`=1 and `err`=0.
- `reset` pulled low during REQ → `mem_req`, `busy` and `mem_data` read 0 immediately; no strobe after release; a fresh `start` completes normally.

Source files
------------

// File: rtl/memory_load_unit.sv
// Single-word memory fetch into the register memory-load path; optional timeout under MEM_LOAD_TIMEOUT_EN.
// Latency: start->mem_req 1 edge, ack->sel_memory 1 edge, min start-to-strobe 2 cycles; outputs registered.
// Backpressure: start is ignored (not queued) while busy; REQ holds until mem_ack (or timeout when compiled in).
module memory_load_unit #(
    parameter int WORD    = 16,
    parameter int ADDR    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [ADDR-1:0] i_addr,
    output logic            o_busy,
    output logic            o_mem_req,
    output logic [ADDR-1:0] o_mem_addr,
    input  logic            i_mem_ack,
    input  logic [WORD-1:0] i_mem_rdata,
    output logic [WORD-1:0] o_mem_data,
    output logic            o_sel_memory,
    output logic            o_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]      r_state;
    logic            r_busy;
    logic            r_mem_req;
    logic [ADDR-1:0] r_mem_addr;
    logic [WORD-1:0] r_mem_data;
    logic            r_sel_memory;

`ifdef MEM_LOAD_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT[7:0];

    logic [7:0] r_cnt;
    logic       r_err;
    logic [7:0] w_cnt_inc;

    // Saturating so a stuck request can never wrap back below the limit.
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_sel_memory <= 1'b0;
`ifdef MEM_LOAD_TIMEOUT_EN
            r_cnt        <= 8'd0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_sel_memory <= 1'b0;
`ifdef MEM_LOAD_TIMEOUT_EN
            r_err        <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_REQ;
                        r_busy     <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= i_addr;
`ifdef MEM_LOAD_TIMEOUT_EN
                        r_cnt      <= 8'd0;
`endif
                    end
                end
                S_REQ: begin
                    // Ack takes priority over a coincident timeout expiry.
                    if (i_mem_ack) begin
                        r_state      <= S_DONE;
                        r_mem_req    <= 1'b0;
                        r_mem_data   <= i_mem_rdata;
                        r_sel_memory <= 1'b1;
                    end
`ifdef MEM_LOAD_TIMEOUT_EN
                    else if (w_cnt_inc >= TIMEOUT_LIM) begin
                        r_state   <= S_ERR;
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_cnt     <= w_cnt_inc;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
`endif
                end
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_data   = r_mem_data;
    assign o_sel_memory = r_sel_memory;
`ifdef MEM_LOAD_TIMEOUT_EN
    assign o_err        = r_err;
`else
    assign o_err        = 1'b0;
`endif

endmodule
